// File: rtl/booth_arith_pkg.sv
// Shared arithmetic-unit definitions for the Booth multiplier and the sequential divider.
// Holds the FSM state encoding and the default operand width.
package booth_arith_pkg;

   localparam int unsigned DIV_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/booth_seq_divider_div_step.sv
// One restoring-division iteration on magnitudes: shift {R,Q} left by one, then
// subtract |divisor| from R if that does not go negative and record the quotient bit.
module booth_seq_divider_div_step #(
   parameter int unsigned W = 8
) (
   input  logic [W:0]   r_i,
   input  logic [W-1:0] q_i,
   input  logic [W-1:0] d_i,
   output logic [W:0]   r_next_c,
   output logic [W-1:0] q_next_c
);

   logic [W+1:0] shifted;
   logic [W+1:0] trial;
   logic         ge;

   always_comb begin
      shifted  = {r_i, q_i[W-1]};
      ge       = (shifted >= {2'b00, d_i});
      trial    = shifted - {2'b00, d_i};
      r_next_c = ge ? trial[W:0] : shifted[W:0];
      q_next_c = {q_i[W-2:0], ge};
   end

endmodule

// File: rtl/booth_seq_divider.sv
// Multi-cycle signed divider: radix-2 restoring iteration on operand magnitudes,
// sign fix-up of quotient and remainder, valid/ready handshake on both sides.
module booth_seq_divider
   import booth_arith_pkg::*;
#(
   parameter int unsigned W = DIV_W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         div_by_zero,
   output logic         overflow
);

   localparam int unsigned  CW       = $clog2(W + 1);
   localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0] ALL_ONES = '1;

   function automatic logic [W-1:0] neg_w(input logic [W-1:0] x);
      return W'(-x);
   endfunction

   // Magnitude as unsigned W bits; the most negative value maps to 2^(W-1).
   function automatic logic [W-1:0] abs_w(input logic [W-1:0] x);
      return x[W-1] ? neg_w(x) : x;
   endfunction

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W:0]    r_q, r_d;
   logic [W-1:0]  q_q, q_d;
   logic [W-1:0]  dvs_q, dvs_d;
   logic          sgnq_q, sgnq_d;
   logic          sgnr_q, sgnr_d;
   logic          special_q, special_d;
   logic [W-1:0]  quot_q, quot_d;
   logic [W-1:0]  rem_q, rem_d;
   logic          dbz_q, dbz_d;
   logic          ovf_q, ovf_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;

   logic          accept_c;
   logic          is_zero_c;
   logic          is_ovf_c;
   logic [W:0]    r_step_c;
   logic [W-1:0]  q_step_c;

   assign accept_c  = (state_q == IDLE) && in_valid;
   assign is_zero_c = (divisor == '0);
   assign is_ovf_c  = (dividend == MIN_NEG) && (divisor == ALL_ONES);

   booth_seq_divider_div_step #(.W(W)) u_step (
      .r_i      (r_q),
      .q_i      (q_q),
      .d_i      (dvs_q),
      .r_next_c (r_step_c),
      .q_next_c (q_step_c)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; special cases bypass the iteration entirely
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (in_valid) state_d = (is_zero_c || is_ovf_c) ? FIX : CALC;
         CALC: if (cnt_q == CW'(1)) state_d = FIX;
         FIX:  state_d = DONE;
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and handshake next values
   always_comb begin
      cnt_d       = cnt_q;
      r_d         = r_q;
      q_d         = q_q;
      dvs_d       = dvs_q;
      sgnq_d      = sgnq_q;
      sgnr_d      = sgnr_q;
      special_d   = special_q;
      quot_d      = quot_q;
      rem_d       = rem_q;
      dbz_d       = dbz_q;
      ovf_d       = ovf_q;
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      unique case (state_q)
         IDLE: begin
            if (accept_c) begin
               cnt_d     = CW'(W);
               r_d       = '0;
               q_d       = abs_w(dividend);
               dvs_d     = abs_w(divisor);
               sgnq_d    = dividend[W-1] ^ divisor[W-1];
               sgnr_d    = dividend[W-1];
               special_d = is_zero_c || is_ovf_c;
               dbz_d     = is_zero_c;
               ovf_d     = is_ovf_c && !is_zero_c;
               if (is_zero_c) begin
                  quot_d = ALL_ONES;
                  rem_d  = dividend;
               end else if (is_ovf_c) begin
                  quot_d = MIN_NEG;
                  rem_d  = '0;
               end
            end
         end
         CALC: begin
            r_d   = r_step_c;
            q_d   = q_step_c;
            cnt_d = cnt_q - CW'(1);
         end
         FIX: begin
            if (!special_q) begin
               quot_d = sgnq_q ? neg_w(q_q) : q_q;
               rem_d  = sgnr_q ? neg_w(r_q[W-1:0]) : r_q[W-1:0];
            end
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         r_q         <= '0;
         q_q         <= '0;
         dvs_q       <= '0;
         sgnq_q      <= 1'b0;
         sgnr_q      <= 1'b0;
         special_q   <= 1'b0;
         quot_q      <= '0;
         rem_q       <= '0;
         dbz_q       <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         r_q         <= r_d;
         q_q         <= q_d;
         dvs_q       <= dvs_d;
         sgnq_q      <= sgnq_d;
         sgnr_q      <= sgnr_d;
         special_q   <= special_d;
         quot_q      <= quot_d;
         rem_q       <= rem_d;
         dbz_q       <= dbz_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_booth_seq_divider.sv
// Self-checking bench for booth_seq_divider (W=8): directed corner cases, backpressure,
// mid-operation async reset, and random operands against an integer-arithmetic model.
module tb_booth_seq_divider;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_by_zero;
   logic       overflow;

   int checks   = 0;
   int failures = 0;

   booth_seq_divider #(.W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: truncating signed division with the two special cases
   task automatic model(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic [7:0] r,
                        output logic dbz, output logic ovf);
      int ai, bi;
      ai  = $signed(a);
      bi  = $signed(b);
      dbz = 1'b0;
      ovf = 1'b0;
      if (bi == 0) begin
         q = 8'hFF; r = a; dbz = 1'b1;
      end else if (ai == -128 && bi == -1) begin
         q = 8'h80; r = 8'h00; ovf = 1'b1;
      end else begin
         q = 8'(ai / bi);
         r = 8'(ai % bi);
      end
   endtask

   task automatic issue(input logic [7:0] a, input logic [7:0] b);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_before_issue", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      dividend = 8'($urandom);
      divisor  = 8'($urandom);
   endtask

   // lat counts edges from the accept edge (counted as 1) to the edge raising out_valid
   task automatic wait_result(output int lat);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("out_valid_within_budget", 32'(out_valid), 32'd1);
   endtask

   task automatic check_result(input string tag, input logic [7:0] eq, input logic [7:0] er,
                               input logic edbz, input logic eovf, input int lat);
      int elat;
      elat = (edbz || eovf) ? 2 : 10;
      check({tag, "_quotient"},  32'(quotient),    32'(eq));
      check({tag, "_remainder"}, 32'(remainder),   32'(er));
      check({tag, "_dbz"},       32'(div_by_zero), 32'(edbz));
      check({tag, "_ovf"},       32'(overflow),    32'(eovf));
      check({tag, "_latency"},   32'(lat),         32'(elat));
      check({tag, "_busy"},      32'(in_ready),    32'd0);
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid_drop", 32'(out_valid), 32'd0);
      check("in_ready_back",  32'(in_ready),  32'd1);
   endtask

   task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic edbz, input logic eovf);
      int lat;
      issue(a, b);
      wait_result(lat);
      check_result(tag, eq, er, edbz, eovf, lat);
      consume();
   endtask

   initial begin
      logic [7:0] a, b, mq, mr;
      logic       mdbz, movf;
      int         lat;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = 8'd0;
      divisor   = 8'd0;
      @(negedge clk);
      check("rst_in_ready",  32'(in_ready),    32'd1);
      check("rst_out_valid", 32'(out_valid),   32'd0);
      check("rst_quotient",  32'(quotient),    32'd0);
      check("rst_remainder", 32'(remainder),   32'd0);
      check("rst_flags",     32'({div_by_zero, overflow}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_op("p100_p7",   8'd100,  8'd7,    8'd14,   8'd2,    1'b0, 1'b0);
      do_op("m100_p7",   8'h9C,   8'd7,    8'hF2,   8'hFE,   1'b0, 1'b0);
      do_op("p100_m7",   8'd100,  8'hF9,   8'hF2,   8'd2,    1'b0, 1'b0);
      do_op("m100_m7",   8'h9C,   8'hF9,   8'd14,   8'hFE,   1'b0, 1'b0);
      do_op("div_zero",  8'd5,    8'd0,    8'hFF,   8'd5,    1'b1, 1'b0);
      do_op("ovf",       8'h80,   8'hFF,   8'h80,   8'd0,    1'b0, 1'b1);
      do_op("min_by_1",  8'h80,   8'd1,    8'h80,   8'd0,    1'b0, 1'b0);
      do_op("small_big", 8'd3,    8'd100,  8'd0,    8'd3,    1'b0, 1'b0);

      // Backpressure: result must hold and new operands must be ignored
      issue(8'd50, 8'hFD);
      wait_result(lat);
      check_result("bp", 8'hF0, 8'd2, 1'b0, 1'b0, lat);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         dividend = 8'd1;
         divisor  = 8'd1;
         @(negedge clk);
         check("bp_hold_valid",    32'(out_valid), 32'd1);
         check("bp_hold_ready",    32'(in_ready),  32'd0);
         check("bp_hold_quotient", 32'(quotient),  32'hF0);
         check("bp_hold_rem",      32'(remainder), 32'd2);
      end
      in_valid = 1'b0;
      consume();
      do_op("after_bp", 8'd127, 8'd127, 8'd1, 8'd0, 1'b0, 1'b0);

      // Async reset in the middle of an iteration
      issue(8'd100, 8'd7);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_in_ready",  32'(in_ready),  32'd1);
      check("arst_quotient",  32'(quotient),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_op("after_rst", 8'd3, 8'd2, 8'd1, 8'd1, 1'b0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         if (i % 10 == 3) b = 8'd0;
         if (i % 10 == 7) b = 8'hFF;
         if (i % 20 == 7) a = 8'h80;
         if (i % 10 == 5) b = 8'($urandom_range(1, 4));
         model(a, b, mq, mr, mdbz, movf);
         do_op("rand", a, b, mq, mr, mdbz, movf);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
